// File: rtl/xbox_xlr_apb_regs_if.sv
// APB bus bundle between the host bridge (master) and the XBOX
// accelerator register bank (slave).
interface xbox_xlr_apb_regs_if #(
    parameter int unsigned APB_AW = 12
) ();
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [APB_AW-1:0] paddr;
    logic [31:0]       pwdata;
    logic [3:0]        pstrb;
    logic              pready;
    logic [31:0]       prdata;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/xbox_xlr_apb_regs.sv
// APB slave holding the 32x32-bit host command/status registers of one XBOX
// accelerator. Writes land in host_regs with a one-cycle per-register pulse;
// reads return either the SW-written value or the accelerator readback.
// A sticky irq is raised on the rising edge of host_regs_valid_out[0] and
// cleared by any successful access to register 0.
module xbox_xlr_apb_regs #(
    parameter int unsigned APB_AW  = 12,
    parameter int unsigned RD_WAIT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    xbox_xlr_apb_regs_if.slave  apb,
    output logic [31:0][31:0]   host_regs,
    output logic [31:0]         host_regs_valid_pulse,
    input  logic [31:0][31:0]   host_regs_data_out,
    input  logic [31:0]         host_regs_valid_out,
    output logic                irq
);

    localparam logic [2:0] RD_WAIT_C = 3'(RD_WAIT);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [31:0][31:0] regs_q, regs_d;
    logic [31:0]      pulse_q, pulse_d;
    logic             irq_q, irq_d;
    logic             vo0_q;

    logic [4:0]       idx;
    logic             addr_err;
    logic             pready;
    logic             xfer_ok;

    assign idx      = apb.paddr[6:2];
    assign addr_err = (apb.paddr[1:0] != 2'b00) | (apb.paddr[APB_AW-1:7] != '0);
    assign pready   = (state_q == ACCESS) && (cnt_q == '0);
    // Side effects only for a live, error-free access phase (abandoned transfers do nothing)
    assign xfer_ok  = pready & apb.psel & apb.penable & ~addr_err;

    assign apb.pready  = pready;
    assign apb.pslverr = addr_err & pready;
    assign apb.prdata  = (pready && !apb.pwrite && !addr_err)
                       ? (host_regs_valid_out[idx] ? host_regs_data_out[idx] : regs_q[idx])
                       : '0;

    assign host_regs             = regs_q;
    assign host_regs_valid_pulse = pulse_q;
    assign irq                   = irq_q;

    // Transfer FSM: setup phase arms the wait counter, access phase counts it down
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (apb.psel && !apb.penable) begin
                    state_d = ACCESS;
                    cnt_d   = apb.pwrite ? '0 : RD_WAIT_C;
                end
            end
            ACCESS: begin
                if (!apb.psel || cnt_q == '0) begin
                    state_d = IDLE;
                end else if (apb.penable) begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Register write with byte strobes, write pulse, and sticky irq (set beats clear)
    always_comb begin
        regs_d  = regs_q;
        pulse_d = '0;
        irq_d   = irq_q;
        if (xfer_ok && apb.pwrite && apb.pstrb != '0) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (apb.pstrb[k]) begin
                    regs_d[idx][8*k +: 8] = apb.pwdata[8*k +: 8];
                end
            end
            pulse_d[idx] = 1'b1;
        end
        if (xfer_ok && idx == '0) begin
            irq_d = 1'b0;
        end
        if (host_regs_valid_out[0] && !vo0_q) begin
            irq_d = 1'b1;
        end
    end

    // State and data registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            regs_q  <= '0;
            pulse_q <= '0;
            irq_q   <= 1'b0;
            vo0_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            regs_q  <= regs_d;
            pulse_q <= pulse_d;
            irq_q   <= irq_d;
            vo0_q   <= host_regs_valid_out[0];
        end
    end

endmodule

// File: tb/tb_xbox_xlr_apb_regs.sv
// Directed bench for xbox_xlr_apb_regs. A transaction-level model (register
// array, expected pulse cycle, irq flag) is updated by the driver tasks and
// checked against the DUT on every falling edge.
module tb_xbox_xlr_apb_regs;

    localparam int unsigned APB_AW  = 12;
    localparam int unsigned RD_WAIT = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [31:0][31:0] host_regs;
    logic [31:0]       pulse;
    logic [31:0][31:0] data_out;
    logic [31:0]       valid_out;
    logic              irq;

    xbox_xlr_apb_regs_if #(.APB_AW(APB_AW)) apb ();

    xbox_xlr_apb_regs #(.APB_AW(APB_AW), .RD_WAIT(RD_WAIT)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .apb                   (apb),
        .host_regs             (host_regs),
        .host_regs_valid_pulse (pulse),
        .host_regs_data_out    (data_out),
        .host_regs_valid_out   (valid_out),
        .irq                   (irq)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [31:0] m_regs [32];
    int          m_pulse_cyc = -1;
    int          m_pulse_idx = 0;
    logic        m_irq = 1'b0;
    logic [31:0] rd;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of DUT state against the model
    always @(negedge clk) begin : compare
        logic [31:0] ep;
        int          bad_idx;
        ep = (cyc == m_pulse_cyc) ? (32'h1 << m_pulse_idx) : 32'h0;
        chk("pulse", pulse, ep);
        chk("irq", {31'h0, irq}, {31'h0, m_irq});
        bad_idx = -1;
        for (int i = 0; i < 32; i++) begin
            if (bad_idx < 0 && host_regs[i] !== m_regs[i]) bad_idx = i;
        end
        n_cmp++;
        if (bad_idx >= 0) begin
            n_bad++;
            $display("FAIL host_regs[%0d]: got %h expected %h (t=%0t)",
                     bad_idx, host_regs[bad_idx], m_regs[bad_idx], $time);
        end
        if (!apb.psel) begin
            chk("idle_pready", {31'h0, apb.pready}, 32'h0);
            chk("idle_pslverr", {31'h0, apb.pslverr}, 32'h0);
            chk("idle_prdata", apb.prdata, 32'h0);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive valid_out[0]; a 0->1 change raises irq after the next edge
    task automatic set_vo0(input logic v);
        logic prev;
        prev = valid_out[0];
        valid_out[0] = v;
        @(posedge clk);
        #1;
        if (v && !prev) m_irq = 1'b1;
    endtask

    // One APB transfer starting now (caller is just after a rising edge).
    // rise_vo0 raises valid_out[0] so that it is seen on the completion edge.
    task automatic apb_xfer(input logic wr, input logic [APB_AW-1:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            input logic rise_vo0, output logic [31:0] rdata);
        logic        err;
        logic [4:0]  idx;
        int          waits;
        logic [31:0] exp_rd;
        err = (addr[1:0] != 2'b00) || (addr[APB_AW-1:7] != '0);
        idx = addr[6:2];
        apb.psel    = 1'b1;
        apb.penable = 1'b0;
        apb.pwrite  = wr;
        apb.paddr   = addr;
        apb.pwdata  = wdata;
        apb.pstrb   = strb;
        @(posedge clk);
        #1;
        apb.penable = 1'b1;
        waits = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!apb.pready && waits < 16);
        if (!apb.pready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pready_timeout: got 0 expected 1 after %0d cycles", waits);
        end
        chk("latency", waits, wr ? 32'd1 : RD_WAIT + 1);
        chk("pslverr", {31'h0, apb.pslverr}, {31'h0, err});
        exp_rd = (err) ? 32'h0 : (valid_out[idx] ? data_out[idx] : m_regs[idx]);
        if (!wr) chk("prdata", apb.prdata, exp_rd);
        rdata = apb.prdata;
        if (rise_vo0) valid_out[0] = 1'b1;
        @(posedge clk);
        #1;
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        if (!err) begin
            if (wr && strb != 4'h0) begin
                for (int k = 0; k < 4; k++) begin
                    if (strb[k]) m_regs[idx][8*k +: 8] = wdata[8*k +: 8];
                end
                m_pulse_idx = idx;
                m_pulse_cyc = cyc;
            end
            if (idx == 5'd0) m_irq = 1'b0;
        end
        if (rise_vo0) m_irq = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "watchdog");
    end

    initial begin
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
        apb.paddr = '0; apb.pwdata = '0; apb.pstrb = '0;
        valid_out = '0;
        data_out  = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_pready", {31'h0, apb.pready}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        rst_n = 1'b1;
        idle(1);

        // Full write of reg 0
        apb_xfer(1'b1, 12'h000, 32'h0000_0001, 4'hF, 1'b0, rd);
        chk("t1_reg0", host_regs[0], 32'h0000_0001);
        chk("t1_pulse", pulse, 32'h0000_0001);
        idle(1);

        // Strobed write, then back-to-back reads from SW copy and readback
        apb_xfer(1'b1, 12'h00C, 32'hAABB_CCDD, 4'b0101, 1'b0, rd);
        chk("t2_reg3", host_regs[3], 32'h00BB_00DD);
        chk("t2_model", m_regs[3], 32'h00BB_00DD);
        apb_xfer(1'b0, 12'h00C, 32'h0, 4'h0, 1'b0, rd);
        chk("t3_rd_sw", rd, 32'h00BB_00DD);
        data_out[3]  = 32'h0000_0005;
        valid_out[3] = 1'b1;
        apb_xfer(1'b0, 12'h00C, 32'h0, 4'h0, 1'b0, rd);
        chk("t3_rd_acc", rd, 32'h0000_0005);
        valid_out[3] = 1'b0;
        idle(1);

        // Decode errors, zero-strobe write, highest register
        apb_xfer(1'b1, 12'h080, 32'hFFFF_FFFF, 4'hF, 1'b0, rd);
        apb_xfer(1'b0, 12'h002, 32'h0, 4'h0, 1'b0, rd);
        chk("t4_rd_err", rd, 32'h0);
        apb_xfer(1'b1, 12'hF7C, 32'h1234_5678, 4'hF, 1'b0, rd);
        apb_xfer(1'b1, 12'h010, 32'h1234_5678, 4'h0, 1'b0, rd);
        apb_xfer(1'b1, 12'h07C, 32'hDEAD_BEEF, 4'hF, 1'b0, rd);
        apb_xfer(1'b1, 12'h07C, 32'h0000_0000, 4'b1000, 1'b0, rd);
        apb_xfer(1'b0, 12'h07C, 32'h0, 4'h0, 1'b0, rd);
        chk("t4_reg31", rd, 32'h00AD_BEEF);
        idle(1);

        // Sticky irq: set on rise, cleared by reg-0 read, set wins over clear
        data_out[0] = 32'hCAFE_0000;
        set_vo0(1'b1);
        chk("t5_set", {31'h0, irq}, 32'h1);
        idle(2);
        apb_xfer(1'b0, 12'h000, 32'h0, 4'h0, 1'b0, rd);
        chk("t5_rd_acc0", rd, 32'hCAFE_0000);
        chk("t5_clr", {31'h0, irq}, 32'h0);
        set_vo0(1'b0);
        idle(1);
        set_vo0(1'b1);
        set_vo0(1'b0);
        idle(1);
        apb_xfer(1'b0, 12'h000, 32'h0, 4'h0, 1'b1, rd);
        chk("t5_set_wins", {31'h0, irq}, 32'h1);
        set_vo0(1'b0);
        idle(1);

        // Reset while a read sits in its wait state
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0;
        apb.paddr = 12'h00C; apb.pstrb = 4'h0;
        @(posedge clk);
        #1;
        apb.penable = 1'b1;
        @(negedge clk);
        chk("t6_wait", {31'h0, apb.pready}, 32'h0);
        #1;
        rst_n = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_irq = 1'b0;
        m_pulse_cyc = -1;
        #1;
        chk("t6_pready", {31'h0, apb.pready}, 32'h0);
        chk("t6_irq", {31'h0, irq}, 32'h0);
        chk("t6_reg3", host_regs[3], 32'h0);
        apb.psel = 1'b0;
        apb.penable = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        apb_xfer(1'b1, 12'h00C, 32'h600D_F00D, 4'hF, 1'b0, rd);
        apb_xfer(1'b0, 12'h00C, 32'h0, 4'h0, 1'b0, rd);
        chk("t6_after", rd, 32'h600D_F00D);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
